// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: debounced three-button mode/speed/pause sequencer for an active-low 4-LED bus
module led_pattern_ctrl #(
  parameter int BASE_DIV   = 25_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_speed,
  input  logic       btn_pause,
  output logic [3:0] led_on,
  output logic [1:0] mode,
  output logic [1:0] speed,
  output logic       paused
);
  localparam int CW = $clog2(BASE_DIV);
  localparam int DW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
  typedef enum logic [1:0] {ROT_L, ROT_R, BOUNCE, BLINK} mode_t;
  logic [2:0] raw, press;
  mode_t st;
  logic [CW-1:0] cnt, last;
  logic [1:0] pos, npos;
  logic up, nup, step;
  logic [3:0] nxt_led;
  assign raw  = {btn_pause, btn_speed, btn_mode};
  assign mode = st;
  for (genvar i = 0; i < 3; i++) begin : g_btn
    logic s1, s2, deb, deb_q;
    logic [DW-1:0] dcnt;
    assign press[i] = deb_q & ~deb;
    // synchronize, then accept a new level only after it has held for DEB_CYCLES
    always_ff @(posedge clk)
      if (!rst_n) begin
        s1    <= 1'b1;
        s2    <= 1'b1;
        deb   <= 1'b1;
        deb_q <= 1'b1;
        dcnt  <= '0;
      end else begin
        s1    <= raw[i];
        s2    <= s1;
        deb_q <= deb;
        if (s2 != deb) begin
          if (dcnt == DW'(DEB_CYCLES - 1)) begin
            deb  <= s2;
            dcnt <= '0;
          end else dcnt <= dcnt + 1'b1;
        end else dcnt <= '0;
      end
  end
  // step timing and next pattern for the current mode
  always_comb begin
    last    = CW'((BASE_DIV >> speed) - 1);
    step    = !paused && cnt == last;
    npos    = up ? pos + 2'd1 : pos - 2'd1;
    nup     = npos == 2'd3 ? 1'b0 : npos == 2'd0 ? 1'b1 : up;
    nxt_led = st == ROT_L  ? {led_on[2:0], led_on[3]} :
              st == ROT_R  ? {led_on[0], led_on[3:1]} :
              st == BOUNCE ? ~(4'b0001 << npos) : ~led_on;
  end
  // mode FSM; a mode press reseeds and suppresses a coincident step
  always_ff @(posedge clk)
    if (!rst_n) begin
      st     <= ROT_L;
      led_on <= 4'b1110;
      speed  <= 2'd0;
      paused <= 1'b0;
      cnt    <= '0;
      pos    <= 2'd0;
      up     <= 1'b1;
    end else begin
      if (press[0]) begin
        st     <= mode_t'(st + 2'd1);
        led_on <= st == BOUNCE ? 4'b1111 : 4'b1110;
        pos    <= 2'd0;
        up     <= 1'b1;
        cnt    <= '0;
      end else if (step) begin
        led_on <= nxt_led;
        pos    <= npos;
        up     <= nup;
        cnt    <= '0;
      end else if (!paused) cnt <= cnt + 1'b1;
      if (press[1]) begin
        speed <= speed + 2'd1;
        cnt   <= '0;
      end
      if (press[2]) paused <= ~paused;
    end
endmodule
